// File: rtl/sat_predictor_table_if.sv
// Lookup/update/status signal bundle for the saturating-counter branch predictor table.
// The requester drives the lookup and update signals; the table drives prediction and status.
interface sat_predictor_table_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 4
);
  localparam int unsigned GHR_W = (HIST_W == 0) ? 1 : HIST_W;

  logic              lookup_valid;
  logic [31:0]       lookup_pc;
  logic              pred_valid;
  logic              prediction;
  logic [IDX_W-1:0]  pred_idx;
  logic              branch;
  logic              taken;
  logic [IDX_W-1:0]  update_idx;
  logic              update_pred;
  logic [GHR_W-1:0]  ghr;
  logic [15:0]       mispredict_cnt;

  modport master (
    output lookup_valid, lookup_pc, branch, taken, update_idx, update_pred,
    input  pred_valid, prediction, pred_idx, ghr, mispredict_cnt
  );

  modport slave (
    input  lookup_valid, lookup_pc, branch, taken, update_idx, update_pred,
    output pred_valid, prediction, pred_idx, ghr, mispredict_cnt
  );
endinterface

// File: rtl/sat_predictor_table.sv
// Table of N-bit saturating counters indexed by PC (bimodal) or PC^GHR (gshare),
// one-cycle lookup latency with same-cycle update bypass and a saturating mispredict counter.
module sat_predictor_table #(
  parameter int unsigned N      = 2,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 4,
  parameter int unsigned MODE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  sat_predictor_table_if.slave    bus
);
  localparam int unsigned TBL_SZ = 1 << IDX_W;
  localparam int unsigned GHR_W  = (HIST_W == 0) ? 1 : HIST_W;
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_RST = N'((1 << (N - 1)) - 1);

  logic [N-1:0]     cnt_q [TBL_SZ];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [15:0]      miss_q, miss_d;
  logic             pred_valid_q;
  logic             prediction_q;
  logic [IDX_W-1:0] pred_idx_q;

  logic [IDX_W-1:0] lkp_idx_c;
  logic [N-1:0]     upd_old_c;
  logic [N-1:0]     cnt_d;
  logic [N-1:0]     lkp_cnt_c;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0]};

  // Index formation, counter update, bypass and history/mispredict next state
  always_comb begin
    lkp_idx_c = bus.lookup_pc[IDX_W+1:2];
    if (MODE == 1) begin
      lkp_idx_c = lkp_idx_c ^ IDX_W'(ghr_q);
    end

    upd_old_c = cnt_q[bus.update_idx];
    cnt_d     = upd_old_c;
    if (bus.taken) begin
      if (upd_old_c != CNT_MAX) cnt_d = upd_old_c + N'(1);
    end else begin
      if (upd_old_c != '0) cnt_d = upd_old_c - N'(1);
    end

    // Same-index update in this cycle wins so the prediction sees the new value
    lkp_cnt_c = cnt_q[lkp_idx_c];
    if (bus.branch && (bus.update_idx == lkp_idx_c)) begin
      lkp_cnt_c = cnt_d;
    end

    ghr_d = ghr_q;
    if (HIST_W == 0) begin
      ghr_d = '0;
    end else if (bus.branch) begin
      ghr_d = GHR_W'({ghr_q, bus.taken});
    end

    miss_d = miss_q;
    if (bus.branch && (bus.update_pred != bus.taken) && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TBL_SZ; i++) begin
        cnt_q[i] <= CNT_RST;
      end
      ghr_q        <= '0;
      miss_q       <= '0;
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      if (bus.branch) begin
        cnt_q[bus.update_idx] <= cnt_d;
      end
      ghr_q        <= ghr_d;
      miss_q       <= miss_d;
      pred_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        prediction_q <= lkp_cnt_c[N-1];
        pred_idx_q   <= lkp_idx_c;
      end
    end
  end

  assign bus.pred_valid     = pred_valid_q;
  assign bus.prediction     = prediction_q;
  assign bus.pred_idx       = pred_idx_q;
  assign bus.ghr            = ghr_q;
  assign bus.mispredict_cnt = miss_q;
endmodule

// File: tb/tb_sat_predictor_table.sv
// Bench for sat_predictor_table: a bimodal and a gshare instance share one stimulus
// stream and are compared against an array-based reference model.
module tb_sat_predictor_table;
  localparam int unsigned N      = 2;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned HIST_W = 4;
  localparam int TBL  = 1 << IDX_W;
  localparam int CMAX = (1 << N) - 1;
  localparam int CRST = (1 << (N - 1)) - 1;
  localparam int THR  = 1 << (N - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             lv;
  logic [31:0]      pc;
  logic             br;
  logic             tk;
  logic             upred;
  logic [IDX_W-1:0] uidx;

  sat_predictor_table_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) b0 ();
  sat_predictor_table_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) b1 ();

  assign b0.lookup_valid = lv;   assign b1.lookup_valid = lv;
  assign b0.lookup_pc    = pc;   assign b1.lookup_pc    = pc;
  assign b0.branch       = br;   assign b1.branch       = br;
  assign b0.taken        = tk;   assign b1.taken        = tk;
  assign b0.update_idx   = uidx; assign b1.update_idx   = uidx;
  assign b0.update_pred  = upred; assign b1.update_pred = upred;

  sat_predictor_table #(.N(N), .IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(0)) u_bim (
    .clk(clk), .reset(reset), .bus(b0));
  sat_predictor_table #(.N(N), .IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(1)) u_gsh (
    .clk(clk), .reset(reset), .bus(b1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: counter values, history and mispredict count as plain integers
  int tbl [TBL];
  int m_ghr;
  int m_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (tbl[i]) tbl[i] = CRST;
    m_ghr  = 0;
    m_miss = 0;
  endfunction

  // Apply current inputs for one clock and check all outputs against the model
  task automatic cycle();
    int  base, i0, i1;
    bit  e_valid;
    base    = int'(pc >> 2) % TBL;
    i0      = base;
    i1      = base ^ m_ghr;
    e_valid = lv;
    if (br) begin
      if (tk) tbl[uidx] = (tbl[uidx] + 1 > CMAX) ? CMAX : tbl[uidx] + 1;
      else    tbl[uidx] = (tbl[uidx] - 1 < 0)    ? 0    : tbl[uidx] - 1;
      if ((upred != tk) && (m_miss < 65535)) m_miss++;
      m_ghr = ((m_ghr << 1) | int'(tk)) % (1 << HIST_W);
    end
    @(posedge clk);
    #1;
    check("bim_pred_valid", 32'(b0.pred_valid), 32'(e_valid));
    check("gsh_pred_valid", 32'(b1.pred_valid), 32'(e_valid));
    if (e_valid) begin
      check("bim_pred_idx", 32'(b0.pred_idx), 32'(i0));
      check("gsh_pred_idx", 32'(b1.pred_idx), 32'(i1));
      check("bim_prediction", 32'(b0.prediction), 32'(tbl[i0] >= THR));
      check("gsh_prediction", 32'(b1.prediction), 32'(tbl[i1] >= THR));
    end
    check("ghr", 32'(b0.ghr), 32'(m_ghr));
    check("ghr_gsh", 32'(b1.ghr), 32'(m_ghr));
    check("mispredict_cnt", 32'(b0.mispredict_cnt), 32'(m_miss));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pred_valid"}, 32'(b0.pred_valid), 32'd0);
    check({tag, "_prediction"}, 32'(b0.prediction), 32'd0);
    check({tag, "_pred_idx"}, 32'(b0.pred_idx), 32'd0);
    check({tag, "_ghr"}, 32'(b0.ghr), 32'd0);
    check({tag, "_miss"}, 32'(b0.mispredict_cnt), 32'd0);
    check({tag, "_gsh_pred_valid"}, 32'(b1.pred_valid), 32'd0);
    check({tag, "_gsh_ghr"}, 32'(b1.ghr), 32'd0);
  endtask

  // Called one time unit after a rising edge; leaves the bench at the same phase
  task automatic do_reset();
    lv = 1'b0; br = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("post_reset_pred_valid", 32'(b0.pred_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; lv = 1'b0; pc = '0; br = 1'b0; tk = 1'b0; uidx = '0; upred = 1'b0;
    model_reset();
    #2;
    check_zero_outputs("init");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("first_after_reset_pred_valid", 32'(b0.pred_valid), 32'd0);

    // Basic lookup after reset: weakly not-taken, index from PC[7:2]
    lv = 1'b1; pc = 32'h40;
    cycle();
    check("lookup40_idx", 32'(b0.pred_idx), 32'h10);
    check("lookup40_pred", 32'(b0.prediction), 32'd0);
    lv = 1'b0;

    // Saturation high, then low, on index 5
    br = 1'b1; uidx = 6'd5; tk = 1'b1; upred = 1'b1;
    repeat (4) cycle();
    br = 1'b0; lv = 1'b1; pc = 32'd5 << 2;
    cycle();
    check("sat_hi_pred", 32'(b0.prediction), 32'd1);
    lv = 1'b0; br = 1'b1; tk = 1'b0; upred = 1'b0;
    repeat (2) cycle();
    br = 1'b0; lv = 1'b1;
    cycle();
    check("two_nt_pred", 32'(b0.prediction), 32'd0);
    lv = 1'b0; br = 1'b1;
    repeat (3) cycle();
    br = 1'b0; lv = 1'b1;
    cycle();
    lv = 1'b0; br = 1'b1; tk = 1'b1;
    cycle();
    br = 1'b0; lv = 1'b1;
    cycle();
    check("sat_lo_then_one_taken", 32'(b0.prediction), 32'd0);

    // History shifts T,N,T -> 0101; gshare lookup of PC 0 uses it
    do_reset();
    br = 1'b1; uidx = 6'd0; upred = 1'b1;
    tk = 1'b1; cycle();
    tk = 1'b0; cycle();
    tk = 1'b1; cycle();
    check("ghr_0101", 32'(b1.ghr), 32'h5);
    br = 1'b0; lv = 1'b1; pc = 32'h0;
    cycle();
    check("gshare_idx", 32'(b1.pred_idx), 32'h05);

    // Same-cycle lookup and taken update on a counter holding 1
    do_reset();
    lv = 1'b1; pc = 32'd7 << 2; br = 1'b1; uidx = 6'd7; tk = 1'b1; upred = 1'b0;
    cycle();
    check("bypass_pred", 32'(b0.prediction), 32'd1);

    // Mispredict counter saturation
    lv = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      br = 1'b1; tk = 1'($urandom); upred = ~tk; uidx = IDX_W'($urandom);
      cycle();
    end
    check("miss_saturated", 32'(b0.mispredict_cnt), 32'hFFFF);
    for (int k = 0; k < 8; k++) begin
      tk = 1'($urandom); upred = tk; uidx = IDX_W'($urandom);
      cycle();
    end
    check("miss_hold", 32'(b0.mispredict_cnt), 32'hFFFF);

    // Randomized mix with frequent lookup/update index collisions
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      lv    = 1'($urandom);
      br    = 1'($urandom);
      tk    = 1'($urandom);
      upred = 1'($urandom);
      uidx  = IDX_W'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) pc = {24'($urandom), 2'b00, uidx} << 2;
      else                           pc = {$urandom_range(0, 15), 2'($urandom)};
      cycle();
    end

    // Reset asserted mid-cycle while a lookup and update are pending
    lv = 1'b1; pc = 32'd9 << 2; br = 1'b1; uidx = 6'd9; tk = 1'b1; upred = 1'b0;
    cycle();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("midcycle_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("resume_pred_valid", 32'(b0.pred_valid), 32'd0);
    br = 1'b0;
    for (int i = 0; i < TBL; i++) begin
      lv = 1'b1; pc = 32'(i) << 2;
      cycle();
    end
    // A single taken step on each entry must cross the threshold if it held 1
    for (int i = 0; i < TBL; i++) begin
      lv = 1'b1; pc = 32'(i) << 2; br = 1'b1; uidx = IDX_W'(i); tk = 1'b1; upred = 1'b1;
      cycle();
      check("reset_value_step", 32'(b0.prediction), 32'd1);
    end
    lv = 1'b0; br = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
